// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Widths, reset PC, IF->ID bus width and the fetch-slot state encoding.
package if_stage_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] RESET_PC = 32'h1c00_0000;
  localparam int unsigned IF_ID_BUS_W = 1 + PC_WIDTH + INST_WIDTH;

  // EMPTY: no instruction
  // LIVE : instruction taken from RAM read data
  // HELD : instruction taken from the stall buffer
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    LIVE  = 2'b10,
    HELD  = 2'b11
  } if_state_t;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: latches the pre-IF PC, buffers RAM data on ID stall,
// flags misaligned fetch, drives {adef, pc, inst} to ID with valid/allowin.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned PW = PC_WIDTH,
  parameter int unsigned IW = INST_WIDTH,
  parameter logic [PW-1:0] RST_PC = RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                preif_to_if_valid_i,
  input  logic [PW-1:0]       preif_pc_i,
  output logic                if_allowin_o,
  output logic [PW-1:0]       pc_o,
  input  logic [IW-1:0]       inst_sram_rdata_i,
  input  logic                id_allowin_i,
  output logic                if_to_id_valid_o,
  output logic [1+PW+IW-1:0]  if_to_id_bus_o,
  input  logic                flush_i,
  input  logic                branch_cancel_i
);

  if_state_t     state_q;
  if_state_t     state_d;
  logic [PW-1:0] pc_r;
  logic [IW-1:0] inst_buf;
  logic          valid_r;
  logic          held_r;
  logic          kill;
  logic          allowin;
  logic          capture;
  logic          adef;
  logic [IW-1:0] inst_sel;
  logic [IW-1:0] inst;

  assign valid_r = (state_q != EMPTY);
  assign held_r  = (state_q == HELD);
  assign kill    = flush_i | branch_cancel_i;
  assign allowin = !valid_r | id_allowin_i | kill;

  // Only a LIVE slot that cannot leave must save the RAM word;
  // the RAM only presents it on this one cycle.
  assign capture = (state_q == LIVE) && !allowin;

  always_comb begin
    state_d = state_q;
    if (allowin) begin
      state_d = preif_to_if_valid_i ? LIVE : EMPTY;
    end else if (state_q == LIVE) begin
      state_d = HELD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      pc_r     <= RST_PC - PW'(4);
      inst_buf <= '0;
    end else begin
      state_q <= state_d;
      if (allowin && preif_to_if_valid_i) begin
        pc_r <= preif_pc_i;
      end
      if (capture) begin
        inst_buf <= inst_sram_rdata_i;
      end
    end
  end

  assign adef     = (pc_r[1:0] != 2'b00);
  assign inst_sel = held_r ? inst_buf : inst_sram_rdata_i;
  assign inst     = adef ? '0 : inst_sel;

  assign if_allowin_o     = allowin;
  assign pc_o             = pc_r;
  assign if_to_id_valid_o = valid_r & !kill;
  assign if_to_id_bus_o   = valid_r ? {adef, pc_r, inst} : '0;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
// Drives pre-IF, RAM data and ID handshake; checks bus, valid, allowin, pc.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pv;
  logic [31:0] ppc;
  logic        allowin;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        id_allowin;
  logic        valid;
  logic [64:0] bus;
  logic        flush;
  logic        bcancel;

  int n_chk = 0;
  int n_fail = 0;

  if_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .preif_to_if_valid_i (pv),
    .preif_pc_i          (ppc),
    .if_allowin_o        (allowin),
    .pc_o                (pc),
    .inst_sram_rdata_i   (rdata),
    .id_allowin_i        (id_allowin),
    .if_to_id_valid_o    (valid),
    .if_to_id_bus_o      (bus),
    .flush_i             (flush),
    .branch_cancel_i     (bcancel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs,
                     input logic [64:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] eb(input logic a, input logic [31:0] p,
                                     input logic [31:0] i);
    return {a, p, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; pv = 0; ppc = 32'h0; rdata = 32'h0;
    id_allowin = 1; flush = 0; bcancel = 0;
    tick(); tick();
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_allowin", allowin, 1);
    chk("rst_pc", pc, 32'h1bff_fffc);
    chk("rst_bus", bus, 0);

    rst = 0; pv = 0;
    tick(); #1;
    chk("idle_valid", valid, 0);
    chk("idle_pc", pc, 32'h1bff_fffc);

    pv = 1; ppc = 32'h1c00_0000;
    #1;
    chk("idle_allowin", allowin, 1);
    tick();
    rdata = 32'h0280_0401; ppc = 32'h1c00_0004;
    #1;
    chk("f0_valid", valid, 1);
    chk("f0_bus", bus, eb(0, 32'h1c00_0000, 32'h0280_0401));
    chk("f0_pc", pc, 32'h1c00_0000);

    tick();
    rdata = 32'h0280_0802; ppc = 32'h1c00_0008;
    #1;
    chk("f1_bus", bus, eb(0, 32'h1c00_0004, 32'h0280_0802));

    tick();
    rdata = 32'h0280_0421; ppc = 32'h1c00_000c; id_allowin = 0;
    #1;
    chk("st1_bus", bus, eb(0, 32'h1c00_0008, 32'h0280_0421));
    chk("st1_allowin", allowin, 0);
    chk("st1_valid", valid, 1);

    tick();
    rdata = 32'hdead_beef;
    #1;
    chk("st2_bus", bus, eb(0, 32'h1c00_0008, 32'h0280_0421));
    chk("st2_pc", pc, 32'h1c00_0008);

    tick();
    rdata = 32'hbad0_0bad;
    #1;
    chk("st3_bus", bus, eb(0, 32'h1c00_0008, 32'h0280_0421));

    tick();
    rdata = 32'h5555_aaaa; id_allowin = 1;
    #1;
    chk("acc_bus", bus, eb(0, 32'h1c00_0008, 32'h0280_0421));
    chk("acc_allowin", allowin, 1);

    tick();
    rdata = 32'h0000_0c0c; ppc = 32'h1c00_0010;
    #1;
    chk("after_bus", bus, eb(0, 32'h1c00_000c, 32'h0000_0c0c));

    bcancel = 1; ppc = 32'h1c00_0100;
    #1;
    chk("bc_valid", valid, 0);
    chk("bc_allowin", allowin, 1);

    tick();
    bcancel = 0; rdata = 32'h1111_0100; ppc = 32'h1c00_0104;
    #1;
    chk("bc_pc", pc, 32'h1c00_0100);
    chk("bc_valid2", valid, 1);
    chk("bc_bus", bus, eb(0, 32'h1c00_0100, 32'h1111_0100));

    id_allowin = 0;
    tick();
    rdata = 32'hffff_0000;
    #1;
    chk("h_bus", bus, eb(0, 32'h1c00_0100, 32'h1111_0100));

    flush = 1; bcancel = 1; ppc = 32'h1c00_8000;
    #1;
    chk("fl_valid", valid, 0);
    chk("fl_allowin", allowin, 1);

    tick();
    flush = 0; bcancel = 0; rdata = 32'h0e0e_0e0e;
    #1;
    chk("fl_bus", bus, eb(0, 32'h1c00_8000, 32'h0e0e_0e0e));
    chk("fl_allowin2", allowin, 0);

    id_allowin = 1; ppc = 32'h1c00_0002;
    tick();
    rdata = 32'h1234_5678; ppc = 32'h1c00_0004;
    #1;
    chk("adef_bus", bus, eb(1, 32'h1c00_0002, 32'h0));
    chk("adef_valid", valid, 1);

    tick();
    rdata = 32'h0280_0c63; id_allowin = 0; ppc = 32'h1c00_0008;
    #1;
    chk("pre_rst_bus", bus, eb(0, 32'h1c00_0004, 32'h0280_0c63));

    tick();
    rdata = 32'h7777_7777;
    #1;
    chk("held_bus", bus, eb(0, 32'h1c00_0004, 32'h0280_0c63));

    rst = 1;
    tick();
    #1;
    chk("mr_valid", valid, 0);
    chk("mr_allowin", allowin, 1);
    chk("mr_pc", pc, 32'h1bff_fffc);
    chk("mr_bus", bus, 0);

    rst = 0; id_allowin = 1; ppc = 32'h1c00_0000;
    tick();
    rdata = 32'h0abc_0def;
    #1;
    chk("mr_reload", bus, eb(0, 32'h1c00_0000, 32'h0abc_0def));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
